rvfi_check_scheduler: RTL

- Sequences a per-channel RVFI checker by driving its `reset` and `check` inputs.
- Holds checker reset, waits a warm-up window, then fires `check` on the first retirement seen on the selected channel.
- Rotates the selected channel round-robin across all NRET retire ports on successive runs.
- Used in simulation and cover benches so one checker instance covers every channel without a separate build per channel.

---
 rtl/rvfi_sched_pkg.sv | 25 ++
 rtl/rvfi_sched_counter.sv | 30 +++
 rtl/rvfi_check_scheduler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rvfi_sched_pkg.sv
// Shared types and helpers for the RVFI check scheduler: state encoding,
// counter sizing and default warm-up/timeout values.
package rvfi_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    WARM  = 3'd2,
    ARMED = 3'd3,
    FIN   = 3'd4
  } sched_state_t;

  localparam int SCHED_SKIP_DEFAULT    = 10;
  localparam int SCHED_TIMEOUT_DEFAULT = 64;

  // One counter serves every timed state, so size it for the longest window.
  function automatic int sched_cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rvfi_sched_counter.sv
// Loadable down-counter shared by the HOLD, WARM and ARMED timers.
module rvfi_sched_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)     cnt_d = load_val;
    else if (dec) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/rvfi_check_scheduler.sv
// Drives reset/check of a single RVFI checker, rotating over all retire channels.
// Define RISCV_FORMAL_SCHED_AUTORESTART_EN to chain runs back-to-back after one start.
module rvfi_check_scheduler
  import rvfi_sched_pkg::*;
#(
  parameter int NRET           = 1,
  parameter int RESET_CYCLES   = 1,
  parameter int SKIP_CYCLES    = SCHED_SKIP_DEFAULT,
  parameter int TIMEOUT_CYCLES = SCHED_TIMEOUT_DEFAULT,
  parameter int CHW            = (NRET > 1) ? $clog2(NRET) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [NRET-1:0] rvfi_valid,
  output logic            chk_reset,
  output logic            check,
  output logic [CHW-1:0]  chk_channel,
  output logic            busy,
  output logic            done,
  output logic            timed_out
);

  localparam int CNTW = sched_cnt_w(RESET_CYCLES, SKIP_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNTW-1:0] RESET_LD = CNTW'(RESET_CYCLES - 1);
  localparam logic [CNTW-1:0] SKIP_LD  = CNTW'((SKIP_CYCLES == 0) ? 0 : SKIP_CYCLES - 1);
  localparam logic [CNTW-1:0] TO_LD    = CNTW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  sched_state_t    state_q, state_d;
  logic            chk_reset_q, chk_reset_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            timed_out_q, timed_out_d;
  logic [CHW-1:0]  chk_channel_q, chk_channel_d;

  logic            cnt_load, cnt_dec, cnt_zero;
  logic [CNTW-1:0] cnt_ld_val, cnt_value;
  logic            valid_sel;

  rvfi_sched_counter #(.W(CNTW)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_ld_val),
    .dec      (cnt_dec & (|cnt_value)),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  // Mux by comparison so a channel index wider than NRET never selects out of range.
  always_comb begin
    valid_sel = 1'b0;
    for (int i = 0; i < NRET; i++)
      if (chk_channel_q == CHW'(i)) valid_sel = rvfi_valid[i];
  end

  assign check = (state_q == ARMED) & valid_sel;

  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_ld_val = '0;
    cnt_dec    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d    = HOLD;
        cnt_load   = 1'b1;
        cnt_ld_val = RESET_LD;
      end
      HOLD: if (cnt_zero) begin
        cnt_load = 1'b1;
        if (SKIP_CYCLES == 0) begin
          state_d    = ARMED;
          cnt_ld_val = TO_LD;
        end else begin
          state_d    = WARM;
          cnt_ld_val = SKIP_LD;
        end
      end else cnt_dec = 1'b1;
      WARM: if (cnt_zero) begin
        state_d    = ARMED;
        cnt_load   = 1'b1;
        cnt_ld_val = TO_LD;
      end else cnt_dec = 1'b1;
      // A retirement in the expiry cycle takes priority over the timeout.
      ARMED: if (check) begin
        state_d  = FIN;
        cnt_load = 1'b1;
      end else if (TIMEOUT_CYCLES != 0) begin
        if (cnt_zero) begin
          state_d  = FIN;
          cnt_load = 1'b1;
        end else cnt_dec = 1'b1;
      end
      FIN: begin
        cnt_load = 1'b1;
`ifdef RISCV_FORMAL_SCHED_AUTORESTART_EN
        state_d    = HOLD;
        cnt_ld_val = RESET_LD;
`else
        state_d    = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    chk_reset_d   = (state_d == HOLD);
    busy_d        = (state_d != IDLE);
    done_d        = (state_q == ARMED) & check;
    timed_out_d   = (state_q == ARMED) & ~check & (state_d == FIN);
    chk_channel_d = chk_channel_q;
    if (state_q == FIN)
      chk_channel_d = (chk_channel_q == CHW'(NRET - 1)) ? '0 : chk_channel_q + CHW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      chk_reset_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      chk_channel_q <= '0;
    end else begin
      state_q       <= state_d;
      chk_reset_q   <= chk_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timed_out_q   <= timed_out_d;
      chk_channel_q <= chk_channel_d;
    end
  end

  assign chk_reset   = chk_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign chk_channel = chk_channel_q;

endmodule
